// File: rtl/adder_osc_counter.sv
// Ring-oscillator edge counter: counts synchronised rising edges of osc_in over a
// programmable window of clk cycles. Optional free-running mode under ADDER_OSC_CONTINUOUS_EN.
module adder_osc_counter #(
  parameter int GATE_W      = 16,
  parameter int COUNT_W     = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
`ifdef ADDER_OSC_CONTINUOUS_EN
  input  logic               continuous,
`endif
  input  logic [GATE_W-1:0]  gate_cycles,
  input  logic               osc_in,
  output logic               osc_enable,
  output logic               ready,
  output logic               done,
  output logic [COUNT_W-1:0] count,
  output logic               overflow,
  output logic [1:0]         dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARM   = 2'd1;
  localparam logic [1:0] S_COUNT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0]   ARM_LAST = ARM_W'(SYNC_STAGES);
  localparam logic [COUNT_W-1:0] CNT_MAX  = '1;
  localparam logic [GATE_W-1:0]  GATE_ONE = GATE_W'(1);

  logic [1:0]             state_q, state_d;
  logic [GATE_W-1:0]      gate_lat_q, gate_lat_d;
  logic [GATE_W-1:0]      gate_cnt_q, gate_cnt_d;
  logic [ARM_W-1:0]       arm_cnt_q, arm_cnt_d;
  logic [COUNT_W-1:0]     count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_prev_q, sync_prev_d;
  logic                   osc_rise;
  logic                   cont;

`ifdef ADDER_OSC_CONTINUOUS_EN
  assign cont = continuous;
`else
  assign cont = 1'b0;
`endif

  // Edge detect on the synchroniser output; only counted while the window is open.
  assign osc_rise = sync_q[SYNC_STAGES-1] & ~sync_prev_q & (state_q == S_COUNT);

  always_comb begin
    state_d     = state_q;
    gate_lat_d  = gate_lat_q;
    gate_cnt_d  = gate_cnt_q;
    arm_cnt_d   = arm_cnt_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    sync_d      = {sync_q[SYNC_STAGES-2:0], osc_in};
    sync_prev_d = sync_q[SYNC_STAGES-1];
    case (state_q)
      S_IDLE, S_DONE: begin
        if ((state_q == S_DONE) && cont && (gate_lat_q != '0)) begin
          state_d    = S_COUNT;
          gate_cnt_d = gate_lat_q;
          count_d    = '0;
          overflow_d = 1'b0;
        end else if (start) begin
          state_d    = S_ARM;
          gate_lat_d = gate_cycles;
          arm_cnt_d  = '0;
          count_d    = '0;
          overflow_d = 1'b0;
        end
      end
      S_ARM: begin
        // Hold long enough for stale oscillator history to leave the synchroniser.
        if (arm_cnt_q == ARM_LAST) begin
          state_d    = (gate_lat_q == '0) ? S_DONE : S_COUNT;
          gate_cnt_d = gate_lat_q;
        end else begin
          arm_cnt_d = arm_cnt_q + 1'b1;
        end
      end
      S_COUNT: begin
        if (osc_rise) begin
          if (count_q == CNT_MAX) overflow_d = 1'b1;
          else                    count_d    = count_q + 1'b1;
        end
        if (gate_cnt_q == GATE_ONE) state_d    = S_DONE;
        else                        gate_cnt_d = gate_cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      gate_lat_q  <= '0;
      gate_cnt_q  <= '0;
      arm_cnt_q   <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gate_lat_q  <= gate_lat_d;
      gate_cnt_q  <= gate_cnt_d;
      arm_cnt_q   <= arm_cnt_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      sync_q      <= sync_d;
      sync_prev_q <= sync_prev_d;
    end
  end

  assign ready      = (state_q == S_IDLE) || (state_q == S_DONE);
  assign done       = (state_q == S_DONE);
  assign osc_enable = (state_q == S_ARM) || (state_q == S_COUNT) || ((state_q == S_DONE) && cont);
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_adder_osc_counter.sv
// Bench for adder_osc_counter: directed windows, scoreboard of expected done time/count/overflow.
module tb_adder_osc_counter;

  typedef struct packed {
    int unsigned cyc;
    logic [23:0] lo;
    logic [23:0] hi;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        start4 = 1'b0;
  logic        continuous = 1'b0;
  logic [15:0] gate_cycles = '0;
  logic [15:0] gate_cycles4 = '0;
  logic        osc_in;
  logic        osc_enable, ready, done, overflow;
  logic [23:0] count;
  logic [1:0]  dbg_state;
  logic        osc_enable4, ready4, done4, overflow4;
  logic [3:0]  count4;
  logic [1:0]  dbg_state4;

  int unsigned cyc = 0;
  int          osc_period = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        exp_q[$];
  exp_t        exp4_q[$];

  adder_osc_counter dut (
    .clk(clk), .reset(reset), .start(start),
`ifdef ADDER_OSC_CONTINUOUS_EN
    .continuous(continuous),
`endif
    .gate_cycles(gate_cycles), .osc_in(osc_in), .osc_enable(osc_enable),
    .ready(ready), .done(done), .count(count), .overflow(overflow), .dbg_state(dbg_state)
  );

  adder_osc_counter #(.COUNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4),
`ifdef ADDER_OSC_CONTINUOUS_EN
    .continuous(1'b0),
`endif
    .gate_cycles(gate_cycles4), .osc_in(osc_in), .osc_enable(osc_enable4),
    .ready(ready4), .done(done4), .count(count4), .overflow(overflow4), .dbg_state(dbg_state4)
  );

  // Clock and cycle count
  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Oscillator model, changes on the falling clock edge
  initial begin
    osc_in = 1'b0;
    forever begin
      if (osc_period == 0) begin
        osc_in = 1'b0;
        @(negedge clk);
      end else begin
        osc_in = 1'b1;
        repeat (osc_period / 2) @(negedge clk);
        osc_in = 1'b0;
        repeat (osc_period - osc_period / 2) @(negedge clk);
      end
    end
  end

  task automatic chk(input string name, input bit ok, input longint act, input longint req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitors: compare on each rising edge of done
  logic done_prev = 1'b0;
  logic done4_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done && !done_prev) begin
      chk("done_expected", exp_q.size() != 0, 1, 0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("done_latency", cyc == e.cyc, cyc, e.cyc);
        chk("count_range", (count >= e.lo) && (count <= e.hi), count, e.lo);
        chk("overflow", overflow == e.ovf, overflow, e.ovf);
      end
    end
    done_prev = done;
  end

  always @(negedge clk) begin
    exp_t e;
    if (done4 && !done4_prev) begin
      chk("done4_expected", exp4_q.size() != 0, 1, 0);
      if (exp4_q.size() != 0) begin
        e = exp4_q.pop_front();
        chk("done4_latency", cyc == e.cyc, cyc, e.cyc);
        chk("count4_sat", ({20'd0, count4} >= e.lo) && ({20'd0, count4} <= e.hi), count4, e.lo);
        chk("overflow4", overflow4 == e.ovf, overflow4, e.ovf);
      end
    end
    done4_prev = done4;
  end

  // Drivers
  task automatic do_start(input logic [15:0] g, output int unsigned n);
    @(negedge clk);
    gate_cycles = g;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = cyc;
  endtask

  task automatic do_start4(input logic [15:0] g, output int unsigned n);
    @(negedge clk);
    gate_cycles4 = g;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    n = cyc;
  endtask

  task automatic push(input int unsigned c, input int lo, input int hi, input logic ovf);
    exp_t e;
    e.cyc = c; e.lo = 24'(lo); e.hi = 24'(hi); e.ovf = ovf;
    exp_q.push_back(e);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || exp4_q.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", exp_q.size() == 0 && exp4_q.size() == 0,
        exp_q.size() + exp4_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    int unsigned n;
    exp_t e4;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_ready", ready == 1'b1, ready, 1);
    chk("rst_done", done == 1'b0, done, 0);
    chk("rst_osc_enable", osc_enable == 1'b0, osc_enable, 0);
    chk("rst_count", count == 24'd0, count, 0);
    chk("rst_overflow", overflow == 1'b0, overflow, 0);

    // Long window, gate_cycles changed after acceptance
    osc_period = 10;
    do_start(16'd1000, n);
    gate_cycles = 16'd7;
    push(n + 1003, 99, 101, 1'b0);
    drain(1500);

    // Zero-length window, started from DONE
    do_start(16'd0, n);
    push(n + 3, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("arm_osc_enable", osc_enable == 1'b1, osc_enable, 1);
      chk("arm_ready", ready == 1'b0, ready, 0);
      @(negedge clk);
    end
    chk("g0_osc_enable_off", osc_enable == 1'b0, osc_enable, 0);
    chk("g0_ready", ready == 1'b1, ready, 1);
    drain(20);

    // start re-pulsed mid-COUNT is ignored
    do_start(16'd200, n);
    push(n + 203, 19, 21, 1'b0);
    repeat (50) @(negedge clk);
    gate_cycles = 16'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain(400);

    // Reset mid-COUNT aborts
    do_start(16'd300, n);
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ready", ready == 1'b1, ready, 1);
    chk("abort_count", count == 24'd0, count, 0);
    chk("abort_osc_enable", osc_enable == 1'b0, osc_enable, 0);
    chk("abort_done", done == 1'b0, done, 0);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    chk("abort_still_idle", ready == 1'b1 && done == 1'b0, {ready, done}, 2);

    // Narrow counter saturates without wrapping
    osc_period = 4;
    do_start4(16'd100, n);
    e4.cyc = n + 103; e4.lo = 24'd15; e4.hi = 24'd15; e4.ovf = 1'b1;
    exp4_q.push_back(e4);
    drain(200);

`ifdef ADDER_OSC_CONTINUOUS_EN
    osc_period = 5;
    continuous = 1'b1;
    do_start(16'd50, n);
    for (int w = 0; w < 4; w++) push(n + 53 + 51 * w, 9, 11, 1'b0);
    while (cyc < n + 170) @(negedge clk);
    continuous = 1'b0;
    drain(200);
    repeat (10) @(negedge clk);
    chk("cont_stopped_done", done == 1'b1, done, 1);
    chk("cont_stopped_osc", osc_enable == 1'b0, osc_enable, 0);
`endif

    osc_period = 0;
    drain(100);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
